vga_dac_ctrl_fml: RTL
=====================

// Module: vga_dac_ctrl_fml
// PURPOSE
//  CPU-side sequencer for the VGA DAC colour registers; sits directly upstream of the PAL/DAC stage.
//  Decodes the four I/O ports 3C6h-3C9h and drives the dac_we / *_data_cycle / *_data_register / write_data
//  bus into the DAC register file. Implements the standard R,G,B three-access cycle with index auto-increment.
//  Handles the synchronous-read latency of the register file with a small handshake state machine.
// PARAMETERS
//  DAC_DW   4  stored colour component width; written from io_dat_i[5:6-DAC_DW]
//  RD_LAT   1  read latency of the DAC register file in clk cycles (1..3)
// PORTS
//  clk                 in   1  system clock (100 MHz)
//  rst_n               in   1  asynchronous reset, active low
//  io_stb              in   1  access request; sampled only while FSM is IDLE
//  io_we               in   1  1 = write, 0 = read (qualified by io_stb)
//  io_adr              in   2  port select: 0=3C6 pel mask, 1=3C7, 2=3C8, 3=3C9
//  io_dat_i            in   8  write data
//  io_dat_o            out  8  read data, valid while io_ack=1
//  io_ack              out  1  one-cycle completion pulse for every accepted access
//  pel_mask            out  8  PEL mask register (3C6)
//  dac_we              out  1  one-cycle write strobe to DAC regs
//  dac_write_data_cycle    out 2       component select for write: 0=R, 1=G, 2=B
//  dac_write_data_register out 8       colour index for write
//  dac_write_data          out DAC_DW  component value for write
//  dac_read_data_cycle     out 2       component select for read
//  dac_read_data_register  out 8       colour index for read
//  dac_read_data           in  DAC_DW  read data from DAC regs, valid RD_LAT cycles after address is stable
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; io_ack=0, io_dat_o=0, dac_we=0; wr_idx=rd_idx=0; wr_cyc=rd_cyc=0;
//   pel_mask=8'hFF; dac_state=0 (write mode); all dac_* outputs 0. Reset mid-access aborts it; no ack is issued.
//  FSM states: IDLE, RD_WAIT, ACK. All accesses except a 3C9 read go IDLE -> ACK -> IDLE (io_ack 1 cycle after io_stb).
//  A 3C9 read goes IDLE -> RD_WAIT (RD_LAT cycles) -> ACK, so io_ack comes RD_LAT+1 cycles after io_stb.
//  io_stb is ignored outside IDLE; the requester holds it until ack. A new access may start the cycle after ACK.
//  3C6 W: pel_mask<=io_dat_i. R: returns pel_mask.
//  3C7 W: rd_idx<=io_dat_i, rd_cyc<=0, dac_state<=3. R: returns {6'b0,dac_state[1:0]}.
//  3C8 W: wr_idx<=io_dat_i, wr_cyc<=0, dac_state<=0. R: returns wr_idx.
//  3C9 W: in the ACK cycle, dac_we=1 with register=wr_idx, cycle=wr_cyc, data=io_dat_i[5:6-DAC_DW] (all registered);
//   then wr_cyc increments; on wr_cyc==2 it returns to 0 and wr_idx increments (255 wraps to 0).
//  3C9 R: dac_read_data_register=rd_idx and dac_read_data_cycle=rd_cyc are held stable through RD_WAIT.
//   io_dat_o={2'b00,dac_read_data,{(6-DAC_DW){1'b0}}}. After ACK, rd_cyc/rd_idx advance with the same wrap rules.
//  Read and write index/cycle counters are independent; a 3C9 write never disturbs rd_*, and vice versa.
//  io_dat_o is updated only in ACK for reads; it holds its last value otherwise (0 after reset). Writes leave it unchanged.
//  dac_we is never asserted except in the ACK cycle of a 3C9 write; it is never asserted for two consecutive cycles.
// TESTING
//  Reset: rst_n low mid-RD_WAIT -> io_ack stays 0; after release pel_mask=FF, 3C8 read=00, 3C7 read=00.
//  Write 3C8=05, then 3C9 = 3F,00,20 -> dac_we pulses with (reg05,cyc0,F),(reg05,cyc1,0),(reg05,cyc2,8); 3C8 reads 06.
//  Write 3C8=FF, then 3C9 x3 -> third write at reg FF cyc2; 3C8 reads 00 (wrap).
//  Write 3C7=05; model returns R=F after RD_LAT; read 3C9 -> ack RD_LAT+1 cycles after stb, io_dat_o=3C; rd_cyc=1; 3C7 reads 03.
//  Hold io_stb across ACK and back-to-back 3C9 writes -> exactly one dac_we per accepted access; no we while busy.
//  Interleave: 3C7=10, 3C8=20, 3C9 write, 3C9 read -> write hits reg 20 cyc0, read uses reg 10 cyc0.

Source files
------------

// File: rtl/vga_dac_ctrl_fml.sv
// CPU-side sequencer for the VGA DAC colour registers (ports 3C6h-3C9h).
// Runs the R,G,B three-access cycle with index auto-increment and waits out the register-file read latency.
module vga_dac_ctrl_fml #(
  parameter int DAC_DW = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_stb,
  input  logic              io_we,
  input  logic [1:0]        io_adr,
  input  logic [7:0]        io_dat_i,
  output logic [7:0]        io_dat_o,
  output logic              io_ack,
  output logic [7:0]        pel_mask,
  output logic              dac_we,
  output logic [1:0]        dac_write_data_cycle,
  output logic [7:0]        dac_write_data_register,
  output logic [DAC_DW-1:0] dac_write_data,
  output logic [1:0]        dac_read_data_cycle,
  output logic [7:0]        dac_read_data_register,
  input  logic [DAC_DW-1:0] dac_read_data
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_t;

  state_t      state, state_nxt;
  logic [1:0]  lat_cnt;
  logic [7:0]  wr_idx, rd_idx;
  logic [1:0]  wr_cyc, rd_cyc, dac_state;
  logic        accept, pal_rd, pal_wr, rd_done;
  logic [7:0]  rd_mux;
  logic [5:0]  rd_comp;

  assign accept  = (state == IDLE) && io_stb;
  assign pal_rd  = accept && !io_we && (io_adr == 2'd3);
  assign pal_wr  = accept &&  io_we && (io_adr == 2'd3);
  assign rd_done = (state == RD_WAIT) && (lat_cnt == 2'd0);
  // Left-justify the stored component into the 6-bit VGA colour field.
  assign rd_comp = 6'(dac_read_data) << (6 - DAC_DW);

  assign io_ack                 = (state == ACK);
  assign dac_read_data_register = rd_idx;
  assign dac_read_data_cycle    = rd_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io_stb) state_nxt = pal_rd ? RD_WAIT : ACK;
      RD_WAIT: if (lat_cnt == 2'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 8'h00;
    case (io_adr)
      2'd0:    rd_mux = pel_mask;
      2'd1:    rd_mux = {6'b0, dac_state};
      2'd2:    rd_mux = wr_idx;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt                 <= 2'd0;
      io_dat_o                <= 8'h00;
      pel_mask                <= 8'hFF;
      dac_state               <= 2'd0;
      wr_idx                  <= 8'h00;
      wr_cyc                  <= 2'd0;
      rd_idx                  <= 8'h00;
      rd_cyc                  <= 2'd0;
      dac_we                  <= 1'b0;
      dac_write_data_cycle    <= 2'd0;
      dac_write_data_register <= 8'h00;
      dac_write_data          <= '0;
    end else begin
      dac_we <= pal_wr;
      if (pal_rd)
        lat_cnt <= 2'(RD_LAT - 1);
      else if (state == RD_WAIT && lat_cnt != 2'd0)
        lat_cnt <= lat_cnt - 2'd1;

      if (accept && io_we) begin
        case (io_adr)
          2'd0: pel_mask <= io_dat_i;
          2'd1: begin
            rd_idx    <= io_dat_i;
            rd_cyc    <= 2'd0;
            dac_state <= 2'd3;
          end
          2'd2: begin
            wr_idx    <= io_dat_i;
            wr_cyc    <= 2'd0;
            dac_state <= 2'd0;
          end
          default: begin
            dac_write_data_register <= wr_idx;
            dac_write_data_cycle    <= wr_cyc;
            dac_write_data          <= io_dat_i[5 -: DAC_DW];
            if (wr_cyc == 2'd2) begin
              wr_cyc <= 2'd0;
              wr_idx <= wr_idx + 8'd1;
            end else begin
              wr_cyc <= wr_cyc + 2'd1;
            end
          end
        endcase
      end

      if (accept && !io_we && io_adr != 2'd3)
        io_dat_o <= rd_mux;

      // Read counters only move once the component has been captured.
      if (rd_done) begin
        io_dat_o <= {2'b00, rd_comp};
        if (rd_cyc == 2'd2) begin
          rd_cyc <= 2'd0;
          rd_idx <= rd_idx + 8'd1;
        end else begin
          rd_cyc <= rd_cyc + 2'd1;
        end
      end
    end
  end

endmodule
